score_counter: RTL
==================

// Module: score_counter
//
// PURPOSE
//   Consumer end of the score tick: counts pulses from clk_div.score_clk
//   (20 Hz) into a packed BCD game score, and keeps a high score across games.
//   A 3-state run FSM (IDLE/RUN/OVER) gates counting.
//   Feeds the seven-segment/VGA score display and the speed-up logic
//   (milestone pulse every 100 points).
//
// PARAMETERS
//   DIGITS      4   number of BCD digits in score_bcd/hi_bcd (legal: 3..8)
//   SAT_ENABLE  1   1: saturate at all-9s; 0: wrap to all-0s
//
// PORTS
//   clk        in   1          system clock
//   rst        in   1          reset, asynchronous, active-high
//   score_clk  in   1          score tick from clk_div; 1-cycle pulse, may be held high
//   start      in   1          1-cycle pulse: clear score, begin counting
//   game_over  in   1          1-cycle pulse: freeze score, update high score
//   score_bcd  out  4*DIGITS   current score, packed BCD, digit 0 in [3:0]
//   hi_bcd     out  4*DIGITS   high score, packed BCD
//   milestone  out  1          1-cycle pulse on each 100-point boundary
//   new_hi     out  1          level: last game set a new high score
//   state      out  2          FSM state: 00 IDLE, 01 RUN, 10 OVER
//
// BEHAVIOUR
// - Reset (async, rst=1): score_bcd=0, hi_bcd=0, milestone=0, new_hi=0,
//   state=IDLE, tick_q=0. Mid-game reset clears hi_bcd too.
// - Tick detect: tick_q <= score_clk each cycle; tick_rise = score_clk & ~tick_q.
//   A held-high score_clk counts once.
//   score_clk high at the first edge after reset counts as a rise.
// - Latency: score_bcd updates on the same clk edge that samples tick_rise=1,
//   so it is visible 1 cycle after score_clk is first high.
// - FSM:
//     IDLE: start -> RUN, score_bcd<=0. game_over ignored. Ticks ignored.
//     RUN:  tick_rise -> increment. game_over -> OVER + hi compare.
//           start ignored.
//     OVER: start -> RUN, score_bcd<=0, new_hi<=0. Ticks and game_over ignored.
//     state 11 is unreachable; if entered, next state is IDLE.
// - Simultaneous events:
//     RUN, game_over and tick_rise together: game_over wins.
//       No increment; the compare uses the held score.
//     IDLE/OVER, start and game_over together: start wins.
// - Increment: ripple BCD. A digit at 9 becomes 0 and carries; otherwise +1.
//   The result never holds a non-BCD nibble.
// - At all-9s:
//     SAT_ENABLE=1: score holds, no milestone.
//     SAT_ENABLE=0: score wraps to 0 and milestone fires.
// - milestone=1 for exactly the cycle after an increment that takes
//   digits[1:0] from 99 to 00. Otherwise 0. Never asserted outside RUN.
// - Hi compare on the RUN->OVER edge: digit-wise magnitude compare from the MSD.
//   If score > hi: hi_bcd<=score_bcd and new_hi<=1 on the same edge.
//   If equal or lower: hi unchanged, new_hi<=0.
// - new_hi holds through OVER and clears on start.
// - All outputs are registered; there are no combinational input-to-output paths.
//
// TESTING
// 1. rst pulse mid-RUN with score=0042, hi=0100 -> all outputs 0, state=IDLE,
//    asynchronously (before next clk edge).
// 2. start, then 7 score_clk pulses (one held 5 cycles)
//    -> score_bcd=0007, each update 1 cycle after rise.
// 3. Preload to 0099 via ticks, 1 more tick -> score_bcd=0100,
//    milestone high exactly 1 cycle.
// 4. SAT_ENABLE=1 at 9999 + tick -> 9999, milestone=0.
//    SAT_ENABLE=0 -> 0000, milestone=1.
// 5. Game 1 ends at 0042 -> hi=0042, new_hi=1.
//    Game 2 ends at 0042 -> hi=0042, new_hi=0.
//    Game 3 ends at 0030 -> hi stays 0042.
// 6. In RUN, game_over and score_clk rise same cycle at 0015
//    -> OVER, score=0015. Later ticks in OVER leave 0015.

Source files
------------

// File: rtl/score_counter_if.sv
// score_counter_if: score tick and game control inputs, BCD score/high-score display outputs
interface score_counter_if #(parameter int DIGITS = 4);
  logic score_clk, start, game_over;
  logic [4*DIGITS-1:0] score_bcd, hi_bcd;
  logic milestone, new_hi;
  logic [1:0] state;
  modport master(output score_clk, start, game_over, input score_bcd, hi_bcd, milestone, new_hi, state);
  modport slave(input score_clk, start, game_over, output score_bcd, hi_bcd, milestone, new_hi, state);
endinterface

// File: rtl/score_counter.sv
// score_counter: BCD game score driven by score tick edges, with high score and run FSM
module score_counter #(
  parameter int DIGITS = 4,
  parameter bit SAT_ENABLE = 1'b1
) (
  input logic clk,
  input logic rst,
  score_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10} state_t;
  state_t state_q, state_d;
  logic tick_q, tick_rise, clr, do_inc, do_over, all9, carry, hold;
  logic milestone_q, new_hi_q;
  logic [4*DIGITS-1:0] score_q, hi_q, inc;
  assign tick_rise = bus.score_clk & ~tick_q;
  assign hold = all9 & SAT_ENABLE;
  always_comb begin
    carry = 1'b1;
    inc = '0;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i+:4] = carry ? (score_q[4*i+:4] == 4'd9 ? 4'd0 : score_q[4*i+:4] + 4'd1) : score_q[4*i+:4];
      carry = carry & (score_q[4*i+:4] == 4'd9);
    end
    all9 = carry;
  end
  always_comb begin
    state_d = state_q;
    clr = 1'b0;
    do_inc = 1'b0;
    do_over = 1'b0;
    case (state_q)
      IDLE: begin
        clr = bus.start;
        state_d = bus.start ? RUN : IDLE;
      end
      RUN: begin
        do_over = bus.game_over;
        do_inc = ~bus.game_over & tick_rise;
        state_d = bus.game_over ? OVER : RUN;
      end
      OVER: begin
        clr = bus.start;
        state_d = bus.start ? RUN : OVER;
      end
      default: state_d = IDLE;
    endcase
  end
  // packed BCD orders the same as its digit-wise magnitude, so a plain compare suffices
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q <= 1'b0;
      score_q <= '0;
      hi_q <= '0;
      milestone_q <= 1'b0;
      new_hi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= bus.score_clk;
      milestone_q <= do_inc & ~hold & (score_q[7:0] == 8'h99);
      if (clr) score_q <= '0;
      else if (do_inc & ~hold) score_q <= inc;
      if (clr) new_hi_q <= 1'b0;
      else if (do_over) new_hi_q <= score_q > hi_q;
      if (do_over && score_q > hi_q) hi_q <= score_q;
    end
  end
  assign bus.score_bcd = score_q;
  assign bus.hi_bcd = hi_q;
  assign bus.milestone = milestone_q;
  assign bus.new_hi = new_hi_q;
  assign bus.state = state_q;
endmodule
